// File: rtl/seq_fsm_pattern_detect_if.sv
// Configuration, serial-bit and status bundle for the serial pattern detector.
// Driven by a master (stimulus/host) and consumed by the detector as slave.
interface seq_fsm_pattern_detect_if #(
    parameter int unsigned P_NBITS     = 4,
    parameter int unsigned P_CNT_NBITS = 8
);
    localparam int unsigned SW = $clog2(P_NBITS + 1);

    logic                   cfg_en;
    logic [P_NBITS-1:0]     cfg_pattern;
    logic                   cfg_overlap;
    logic                   in_val;
    logic                   in_;
    logic [SW-1:0]          state;
    logic                   match;
    logic [P_CNT_NBITS-1:0] count;

    modport master (
        output cfg_en, cfg_pattern, cfg_overlap, in_val, in_,
        input  state, match, count
    );

    modport slave (
        input  cfg_en, cfg_pattern, cfg_overlap, in_val, in_,
        output state, match, count
    );
endinterface

// File: rtl/seq_fsm_pattern_detect.sv
// Serial bit-pattern detector: tracks matched-prefix length of a loadable pattern,
// flags a full match (Moore) and keeps a saturating match count.
module seq_fsm_pattern_detect #(
    parameter int unsigned P_NBITS     = 4,
    parameter int unsigned P_CNT_NBITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    seq_fsm_pattern_detect_if.slave   bus
);
    localparam int unsigned            SW      = $clog2(P_NBITS + 1);
    localparam logic [SW-1:0]          S_FULL  = SW'(P_NBITS);
    localparam logic [P_CNT_NBITS-1:0] CNT_MAX = '1;

    logic [SW-1:0]          state_q, state_d, step_s;
    logic                   match_q, match_d;
    logic [P_CNT_NBITS-1:0] count_q, count_d;
    logic [P_NBITS-1:0]     pat_q, pat_d;
    logic                   ovl_q, ovl_d;

    // Longest pattern prefix that is a suffix of (matched prefix ++ new bit).
    function automatic logic [SW-1:0] next_state(
        input logic [SW-1:0]      s,
        input logic               b,
        input logic [P_NBITS-1:0] p,
        input logic               ovl
    );
        logic [P_NBITS:0]   w;
        logic [P_NBITS-1:0] ps;
        int unsigned        sv;
        int unsigned        cap;
        logic               ok;
        logic [SW-1:0]      best;
        best = '0;
        sv   = 32'(s);
        if (s == S_FULL && !ovl) begin
            best = (b == p[P_NBITS-1]) ? SW'(1) : '0;
        end else begin
            // Low bits of w hold the most recent bits, newest at w[0].
            w   = {1'b0, p} >> (P_NBITS - sv);
            w   = {w[P_NBITS-1:0], b};
            cap = (s == S_FULL) ? P_NBITS : sv + 1;
            for (int unsigned k = 1; k <= P_NBITS; k++) begin
                ps = p >> (P_NBITS - k);
                ok = (k <= cap);
                for (int unsigned j = 0; j < P_NBITS; j++) begin
                    if (j < k && w[j] != ps[j]) ok = 1'b0;
                end
                if (ok) best = SW'(k);
            end
        end
        return best;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            match_q <= 1'b0;
            count_q <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            count_q <= count_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
        end
    end

    // Next-state and output logic; configuration load wins over data.
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        count_d = count_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        step_s  = next_state(state_q, bus.in_, pat_q, ovl_q);
        if (bus.cfg_en) begin
            pat_d   = bus.cfg_pattern;
            ovl_d   = bus.cfg_overlap;
            state_d = '0;
            match_d = 1'b0;
            count_d = '0;
        end else if (bus.in_val) begin
            state_d = step_s;
            match_d = (step_s == S_FULL);
            if (step_s == S_FULL && count_q != CNT_MAX) begin
                count_d = count_q + P_CNT_NBITS'(1);
            end
        end
    end

    assign bus.state = state_q;
    assign bus.match = match_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_seq_fsm_pattern_detect.sv
// Bench for seq_fsm_pattern_detect: directed scenarios plus random traffic checked
// against a bit-history reference model; a second instance uses a 2-bit counter.
module tb_seq_fsm_pattern_detect;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic reset;

    seq_fsm_pattern_detect_if #(.P_NBITS(4), .P_CNT_NBITS(8)) bus ();
    seq_fsm_pattern_detect_if #(.P_NBITS(4), .P_CNT_NBITS(2)) bus2 ();

    seq_fsm_pattern_detect #(.P_NBITS(4), .P_CNT_NBITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    seq_fsm_pattern_detect #(.P_NBITS(4), .P_CNT_NBITS(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: recent accepted bits, searched for the longest pattern prefix.
    bit       hist[$];
    bit [3:0] m_pat;
    bit       m_ovl;
    int       m_state;
    int       m_cnt;
    int       m_cnt2;

    function automatic int longest();
        bit ok;
        for (int k = 4; k >= 1; k--) begin
            if (k <= hist.size()) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (hist[hist.size() - k + j] != m_pat[3 - j]) ok = 1'b0;
                end
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_pat   = 4'b0000;
        m_ovl   = 1'b1;
        hist.delete();
        m_state = 0;
        m_cnt   = 0;
        m_cnt2  = 0;
    endtask

    task automatic model_step(input bit ce, input bit [3:0] cp, input bit co,
                              input bit iv, input bit b);
        if (ce) begin
            m_pat   = cp;
            m_ovl   = co;
            hist.delete();
            m_state = 0;
            m_cnt   = 0;
            m_cnt2  = 0;
        end else if (iv) begin
            hist.push_back(b);
            if (hist.size() > N) void'(hist.pop_front());
            m_state = longest();
            if (m_state == 4) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
                // Without overlap a completed match consumes its bits.
                if (!m_ovl) hist.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_state"},  32'(bus.state),  32'(m_state));
        chk({tag, "_match"},  32'(bus.match),  32'(m_state == 4));
        chk({tag, "_count"},  32'(bus.count),  32'(m_cnt));
        chk({tag, "_state2"}, 32'(bus2.state), 32'(m_state));
        chk({tag, "_match2"}, 32'(bus2.match), 32'(m_state == 4));
        chk({tag, "_count2"}, 32'(bus2.count), 32'(m_cnt2));
    endtask

    task automatic step(input string tag, input bit ce, input bit [3:0] cp, input bit co,
                        input bit iv, input bit b);
        bus.cfg_en  = ce;  bus.cfg_pattern  = cp; bus.cfg_overlap  = co;
        bus.in_val  = iv;  bus.in_          = b;
        bus2.cfg_en = ce;  bus2.cfg_pattern = cp; bus2.cfg_overlap = co;
        bus2.in_val = iv;  bus2.in_         = b;
        @(posedge clk);
        #1;
        model_step(ce, cp, co, iv, b);
        check_all(tag);
    endtask

    // Accepted data bit; cfg_pattern/cfg_overlap carry junk to show they are ignored.
    task automatic feed(input string tag, input bit b);
        step(tag, 1'b0, 4'($urandom), 1'($urandom), 1'b1, b);
    endtask

    task automatic cfg(input string tag, input bit [3:0] p, input bit o);
        step(tag, 1'b1, p, o, 1'b0, 1'($urandom));
    endtask

    initial begin
        bit b1011[7];
        int e27[7];
        int e28[7];
        int e29[6];

        b1011 = '{1, 0, 1, 1, 0, 1, 1};
        e27   = '{1, 2, 3, 4, 2, 3, 4};
        e28   = '{1, 2, 3, 4, 0, 1, 1};
        e29   = '{1, 2, 3, 4, 4, 4};

        reset = 1'b0;
        bus.cfg_en  = 1'b0; bus.cfg_pattern  = '0; bus.cfg_overlap  = 1'b0; bus.in_val  = 1'b0; bus.in_  = 1'b0;
        bus2.cfg_en = 1'b0; bus2.cfg_pattern = '0; bus2.cfg_overlap = 1'b0; bus2.in_val = 1'b0; bus2.in_ = 1'b0;
        model_reset();
        #7;
        check_all("reset");
        #3 reset = 1'b1;

        // Reset pattern is all-zero with overlap on: zeros are detected.
        for (int i = 0; i < 5; i++) feed("zero_pat", 1'b0);
        chk("zero_pat_final_count", 32'(bus.count), 32'd2);

        cfg("r27_cfg", 4'b1011, 1'b1);
        for (int i = 0; i < 7; i++) begin
            feed("r27", b1011[i]);
            chk("r27_state_const", 32'(bus.state), 32'(e27[i]));
        end
        chk("r27_final_count", 32'(bus.count), 32'd2);

        cfg("r28_cfg", 4'b1011, 1'b0);
        for (int i = 0; i < 7; i++) begin
            feed("r28", b1011[i]);
            chk("r28_state_const", 32'(bus.state), 32'(e28[i]));
        end
        chk("r28_final_count", 32'(bus.count), 32'd1);

        cfg("r29_cfg", 4'b1111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            feed("r29", 1'b1);
            chk("r29_state_const", 32'(bus.state), 32'(e29[i]));
        end
        chk("r29_count", 32'(bus.count), 32'd3);
        step("r29_cfg_prio", 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
        chk("r29_prio_state", 32'(bus.state), 32'd0);
        chk("r29_prio_count", 32'(bus.count), 32'd0);

        cfg("r30_cfg", 4'b1011, 1'b1);
        feed("r30", 1'b1);
        feed("r30", 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("r30_stall", 1'b0, 4'($urandom), 1'($urandom), 1'b0, 1'(i % 2));
            chk("r30_stall_state", 32'(bus.state), 32'd2);
        end
        feed("r30", 1'b1);
        chk("r30_state3", 32'(bus.state), 32'd3);
        feed("r30", 1'b1);
        chk("r30_state4", 32'(bus.state), 32'd4);
        chk("r30_count", 32'(bus.count), 32'd1);

        // Narrow counter saturates at 3 and never wraps.
        cfg("r32_cfg", 4'b1111, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            feed("r32", 1'b1);
            chk("r32_count2", 32'(bus2.count), 32'((i < 4) ? 0 : ((i - 3 > 3) ? 3 : i - 3)));
            chk("r32_match2", 32'(bus2.match), 32'(i >= 4));
        end

        cfg("r31_cfg", 4'b1011, 1'b1);
        feed("r31", 1'b1); feed("r31", 1'b0); feed("r31", 1'b1); feed("r31", 1'b1);
        for (int i = 0; i < 4; i++) begin
            feed("r31", 1'b0); feed("r31", 1'b1); feed("r31", 1'b1);
        end
        feed("r31", 1'b0); feed("r31", 1'b1);
        chk("r31_pre_state", 32'(bus.state), 32'd3);
        chk("r31_pre_count", 32'(bus.count), 32'd5);
        #2 reset = 1'b0;
        #1;
        chk("r31_async_state", 32'(bus.state), 32'd0);
        chk("r31_async_match", 32'(bus.match), 32'd0);
        chk("r31_async_count", 32'(bus.count), 32'd0);
        #3 reset = 1'b1;
        model_reset();
        cfg("r31_recfg", 4'b1011, 1'b1);
        for (int i = 0; i < 7; i++) begin
            feed("r31_post", b1011[i]);
            chk("r31_post_state_const", 32'(bus.state), 32'(e27[i]));
        end
        chk("r31_post_count", 32'(bus.count), 32'd2);

        // Random traffic with occasional reconfiguration.
        for (int i = 0; i < 600; i++) begin
            bit ce;
            bit iv;
            ce = ($urandom_range(0, 39) == 0);
            iv = ($urandom_range(0, 3) != 0);
            step("rand", ce, 4'($urandom), 1'($urandom), iv, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
